alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 32-bit add/sub unit.
- Captures the adder result, its four flags and the destination tag, and buffers them through a 2-entry skid buffer with valid/ready handshake toward writeback.
- Maintains the architectural flag register {Z,C,N,V} and evaluates a 4-bit branch condition against it for the branch unit.

Parameters:
DATA_W, 32, width of result datapath
RD_W, 5, width of destination register tag

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result this cycle
in_result  input  DATA_W  adder sum/difference
in_z  input  1  zero flag from adder
in_c  input  1  carry flag from adder (1 = no borrow on subtract)
in_n  input  1  sign flag from adder
in_v  input  1  overflow flag from adder
in_rd  input  RD_W  destination register index
in_we  input  1  result is to be written to register file
in_setf  input  1  instruction updates flag register
flush  input  1  discard all buffered results (pipeline kill)
out_valid  output  1  result available to writeback
out_ready  input  1  writeback consumes result
out_result  output  DATA_W  buffered result
out_rd  output  RD_W  buffered destination index
out_we  output  1  buffered write enable
flags  output  4  architectural flags {Z,C,N,V}
cond  input  4  branch condition code
cond_true  output  1  cond satisfied by current flags

Behaviour:
- Reset (rst_n low, async): both entries invalid, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_we=0, flags=4'b0000. Reset mid-transfer drops all contents.
- Storage: main entry (drives outputs) and skid entry. Each entry holds {result, rd, we}. Order is strict FIFO.
- in_ready = !skid_valid, driven from a register, with no combinational path from out_ready.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- State EMPTY (no valid entries):
  - accept loads main; next state ONE.
- State ONE (main valid):
  - accept & pop: main <= new; stay ONE.
  - accept & !pop: skid <= new; next FULL.
  - pop only: next EMPTY.
- State FULL (main and skid valid; in_ready=0):
  - pop: main <= skid; next ONE.
  - otherwise hold.
- Latency: an accepted result is visible on out_* the next cycle when the stage was EMPTY, or when it was ONE with a simultaneous pop.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Flags:
  - On accept with in_setf=1, flags <= {in_z,in_c,in_n,in_v} at that same edge, independent of writeback backpressure.
  - in_setf=0 leaves flags unchanged.
- Flush (synchronous, highest priority):
  - Next cycle: both entries invalid, out_valid=0, in_ready=1.
  - An accept in the flush cycle is discarded and does not update flags.
  - Flags already committed are not rolled back.
  - out_* data registers may retain stale values; consumers qualify with out_valid.
- cond_true is combinational from the flags register only, never from in_* flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
- No arithmetic is performed; the result passes through bit-exact.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with FULL contents -> immediately out_valid=0, flags=0, in_ready=1; after release, cond=14 -> cond_true=1, cond=0 -> cond_true=0.
- Single transfer: out_ready=1, accept {result=0x0000_0005, rd=3, we=1} -> next cycle out_valid=1, out_result=5, out_rd=3; following cycle out_valid=0.
- Backpressure: out_ready=0, push A=0x11, B=0x22 on consecutive cycles -> in_ready=0 after B; third push is ignored; raising out_ready yields A then B in order, with in_ready=1 after A pops.
- Flags and condition: accept a subtract 5-7 {result=0xFFFF_FFFE, z=0, c=0, n=1, v=0, setf=1} -> flags=4'b0010, LT=1, CC=1, GE=0, HI=0; then accept 7-7 {z=1, c=1, n=0, v=0, setf=1} -> EQ=1, LS=1, GT=0; then accept with setf=0 -> flags unchanged.
- Flush: FULL state plus flush=1 together with in_valid=1, setf=1, z=1 -> next cycle out_valid=0, in_ready=1, flags unchanged.
- Simultaneous push/pop: in ONE state with in_valid=1 and out_ready=1 continuously for 8 cycles on an incrementing stream -> one result per cycle, in_ready stays 1, no skid use, no loss or duplication.

Source files
------------

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Adder result register with 2-entry skid buffer toward writeback,
//            architectural flag register and branch-condition evaluation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_n,
  input  logic              in_v,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_setf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic [3:0]        flags,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_ONE   = 2'd1;
  localparam logic [1:0] c_ST_FULL  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic              r_inReady;
  logic              r_outValid;

  logic [DATA_W-1:0] r_mainResult;
  logic [RD_W-1:0]   r_mainRd;
  logic              r_mainWe;
  logic [DATA_W-1:0] r_skidResult;
  logic [RD_W-1:0]   r_skidRd;
  logic              r_skidWe;
  logic [3:0]        r_flags;

  logic              w_accept;
  logic              w_pop;
  logic              w_loadMainIn;
  logic              w_loadMainSkid;
  logic              w_loadSkid;
  logic              w_flagWrite;

  assign w_accept = in_valid & r_inReady;
  assign w_pop    = r_outValid & out_ready;

  // State register; handshake outputs are registered copies of the next state
  // so in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != c_ST_FULL);
      r_outValid <= (w_nextState != c_ST_EMPTY);
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = c_ST_EMPTY;
    end else begin
      case (r_state)
        c_ST_EMPTY: if (w_accept) w_nextState = c_ST_ONE;
        c_ST_ONE: begin
          if (w_accept && !w_pop)      w_nextState = c_ST_FULL;
          else if (!w_accept && w_pop) w_nextState = c_ST_EMPTY;
        end
        c_ST_FULL:  if (w_pop) w_nextState = c_ST_ONE;
        default:    w_nextState = c_ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (!flush) begin
      case (r_state)
        c_ST_EMPTY: w_loadMainIn = w_accept;
        c_ST_ONE: begin
          w_loadMainIn = w_accept & w_pop;
          w_loadSkid   = w_accept & ~w_pop;
        end
        c_ST_FULL:  w_loadMainSkid = w_pop;
        default: begin
          w_loadMainIn   = 1'b0;
          w_loadMainSkid = 1'b0;
          w_loadSkid     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainResult <= '0;
      r_mainRd     <= '0;
      r_mainWe     <= 1'b0;
    end else if (w_loadMainIn) begin
      r_mainResult <= in_result;
      r_mainRd     <= in_rd;
      r_mainWe     <= in_we;
    end else if (w_loadMainSkid) begin
      r_mainResult <= r_skidResult;
      r_mainRd     <= r_skidRd;
      r_mainWe     <= r_skidWe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skidResult <= '0;
      r_skidRd     <= '0;
      r_skidWe     <= 1'b0;
    end else if (w_loadSkid) begin
      r_skidResult <= in_result;
      r_skidRd     <= in_rd;
      r_skidWe     <= in_we;
    end
  end

  // Flags commit at accept time, regardless of writeback backpressure.
  assign w_flagWrite = w_accept & in_setf & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_flagWrite) begin
      r_flags <= {in_z, in_c, in_n, in_v};
    end
  end

  // Odd codes are the complement of the preceding even code (AL/NV included).
  logic w_fZ, w_fC, w_fN, w_fV;
  logic w_condBase;

  assign {w_fZ, w_fC, w_fN, w_fV} = r_flags;

  always_comb begin
    w_condBase = 1'b0;
    case (cond[3:1])
      3'd0: w_condBase = w_fZ;
      3'd1: w_condBase = w_fC;
      3'd2: w_condBase = w_fN;
      3'd3: w_condBase = w_fV;
      3'd4: w_condBase = w_fC & ~w_fZ;
      3'd5: w_condBase = ~(w_fN ^ w_fV);
      3'd6: w_condBase = ~w_fZ & ~(w_fN ^ w_fV);
      3'd7: w_condBase = 1'b1;
      default: w_condBase = 1'b0;
    endcase
  end

  assign cond_true  = w_condBase ^ cond[0];

  assign in_ready   = r_inReady;
  assign out_valid  = r_outValid;
  assign out_result = r_mainResult;
  assign out_rd     = r_mainRd;
  assign out_we     = r_mainWe;
  assign flags      = r_flags;

endmodule

`default_nettype wire
